// File: rtl/iob_cache_pkg.sv
// Shared definitions for the byte-strobe single-port RAM controller:
// controller states and byte/strobe width constants.
package iob_cache_pkg;

  localparam int BYTE_W     = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRB_W = DEF_DATA_W / BYTE_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

endpackage

// File: rtl/iob_byte_merge.sv
// Combinational byte merge: each output byte comes from the new word when its
// strobe is set, otherwise from the old word.
module iob_byte_merge
  import iob_cache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]        i_old,
  input  logic [DATA_W-1:0]        i_new,
  input  logic [DATA_W/BYTE_W-1:0] i_strb,
  output logic [DATA_W-1:0]        o_merged
);

  for (genvar g = 0; g < DATA_W / BYTE_W; g++) begin : g_byte
    assign o_merged[g*BYTE_W +: BYTE_W] = i_strb[g] ? i_new[g*BYTE_W +: BYTE_W]
                                                    : i_old[g*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/iob_sp_ram_bstrb_ctrl.sv
// Front-end controller for an external single-port RAM: reads with latency 1,
// full-word writes in one cycle, partial-strobe writes as a 2-cycle read-modify-write.
module iob_sp_ram_bstrb_ctrl
  import iob_cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  output logic                    ready,
  output logic                    rvalid,
  output logic [DATA_W-1:0]       rdata,
  input  logic                    rready,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_din,
  input  logic [DATA_W-1:0]       ram_dout
);

  localparam int STRB_W = DATA_W / BYTE_W;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rvalid;
  logic                w_rvalid_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;

  logic                w_ready;
  logic                w_accept;
  logic                w_is_read;
  logic                w_is_full;
  logic                w_is_part;
  logic [DATA_W-1:0]   w_merged;

  // ready is gated by reset_n so nothing is accepted while reset is held
  assign w_ready   = reset_n && (r_state == ST_IDLE) && (!r_rvalid || rready);
  assign w_accept  = valid && w_ready;
  assign w_is_read = (wstrb == '0);
  assign w_is_full = (wstrb == '1);
  assign w_is_part = !w_is_read && !w_is_full;

  assign ready  = w_ready;
  assign rvalid = r_rvalid;
  // RAM output is held while no read is issued, so it doubles as the response register
  assign rdata  = ram_dout;

  iob_byte_merge #(
    .DATA_W (DATA_W)
  ) u_byte_merge (
    .i_old    (ram_dout),
    .i_new    (r_wdata),
    .i_strb   (r_wstrb),
    .o_merged (w_merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_accept && w_is_part) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_wstrb <= wstrb;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_part) w_state_nxt = ST_RMW;
      ST_RMW:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new read accepted alongside consumption keeps rvalid up for streaming
  always_comb begin
    w_rvalid_nxt = r_rvalid;
    if (w_accept && w_is_read) begin
      w_rvalid_nxt = 1'b1;
    end else if (r_rvalid && rready) begin
      w_rvalid_nxt = 1'b0;
    end
  end

  // Reset during RMW suppresses the merged write
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr;
    ram_din  = wdata;
    if (reset_n) begin
      if (r_state == ST_RMW) begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = r_addr;
        ram_din  = w_merged;
      end else if (w_accept) begin
        ram_en = 1'b1;
        ram_we = w_is_full;
      end
    end
  end

endmodule

// File: tb/tb_iob_sp_ram_bstrb_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, compared each
// cycle against a transaction-level memory model.
module tb_iob_sp_ram_bstrb_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          rready;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_sp_ram_bstrb_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid    (valid),
    .addr     (addr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .ready    (ready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rready   (rready),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // External RAM device: registered read port, output held when not reading
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  // Reference model: memory contents plus pending-response / pending-merge state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_busy = 1'b0;
  bit            m_rvalid = 1'b0;
  bit            m_known = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_rdata;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < SW; b++)
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare combinational outputs, advance the model
  task automatic cyc(input logic rn, input logic v, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [SW-1:0] s, input logic rr);
    logic e_ready;
    logic acc;
    reset_n = rn; valid = v; addr = a; wdata = d; wstrb = s; rready = rr;
    #1;
    e_ready = rn && !m_busy && (!m_rvalid || rr);
    acc = v && e_ready;
    check("ready", {31'b0, ready}, {31'b0, e_ready});
    if (m_known) begin
      check("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
      if (m_rvalid) check("rdata", rdata, m_rdata);
    end
    if (rn && m_busy) begin
      check("rmw_en", {31'b0, ram_en}, 32'd1);
      check("rmw_we", {31'b0, ram_we}, 32'd1);
      check("rmw_addr", {22'b0, ram_addr}, {22'b0, m_addr});
      check("rmw_din", ram_din, merge(ref_mem[m_addr], m_wdata, m_wstrb));
    end else if (acc) begin
      check("acc_en", {31'b0, ram_en}, 32'd1);
      check("acc_we", {31'b0, ram_we}, {31'b0, (s == '1)});
      check("acc_addr", {22'b0, ram_addr}, {22'b0, a});
      if (s == '1) check("acc_din", ram_din, d);
    end else begin
      check("idle_en", {31'b0, ram_en}, 32'd0);
      if (!rn) check("rst_we", {31'b0, ram_we}, 32'd0);
    end
    @(posedge clk);
    if (!rn) begin
      m_busy = 1'b0;
      m_rvalid = 1'b0;
      m_known = 1'b1;
    end else if (m_busy) begin
      ref_mem[m_addr] = merge(ref_mem[m_addr], m_wdata, m_wstrb);
      m_busy = 1'b0;
    end else begin
      if (m_rvalid && rr) m_rvalid = 1'b0;
      if (acc) begin
        if (s == '0) begin
          m_rvalid = 1'b1;
          m_rdata = ref_mem[a];
        end else if (s == '1) begin
          ref_mem[a] = d;
        end else begin
          m_busy = 1'b1;
          m_addr = a; m_wdata = d; m_wstrb = s;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_dout = '0;

    // Reset with a pending request: nothing may be accepted
    cyc(1'b0, 1'b1, 10'h005, 32'h1, 4'hF, 1'b1);
    cyc(1'b0, 1'b1, 10'h005, 32'h1, 4'h0, 1'b1);

    // Full write then read
    cyc(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b1);
    cyc(1'b1, 1'b1, 10'h005, 32'h0, 4'h0, 1'b1);
    check("rd_005", rdata, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);

    // Backpressure: response held for 5 cycles with a blocked request pending
    cyc(1'b1, 1'b1, 10'h005, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 10'h007, 32'h0, 4'h0, 1'b0);
    check("bp_rdata", rdata, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);

    // Partial write merge
    cyc(1'b1, 1'b1, 10'h010, 32'h11223344, 4'hF, 1'b1);
    cyc(1'b1, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101, 1'b1);
    cyc(1'b1, 1'b1, 10'h010, 32'h0, 4'h0, 1'b1);
    cyc(1'b1, 1'b1, 10'h010, 32'h0, 4'h0, 1'b1);
    check("merge_010", rdata, 32'h11BB33DD);
    cyc(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);

    // Partial write then immediate read of the same word
    cyc(1'b1, 1'b1, 10'h030, 32'h12345678, 4'b0011, 1'b1);
    cyc(1'b1, 1'b1, 10'h030, 32'h0, 4'h0, 1'b1);
    cyc(1'b1, 1'b1, 10'h030, 32'h0, 4'h0, 1'b1);
    check("merge_030", rdata, 32'h00005678);
    cyc(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);

    // Streaming reads, one per cycle
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, AW'(i), 32'hA0A0_0000 + 32'(i), 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, AW'(i), 32'h0, 4'h0, 1'b1);
      check("stream", rdata, 32'hA0A0_0000 + 32'(i));
    end
    cyc(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);

    // Reset during RMW aborts the merge
    cyc(1'b1, 1'b1, 10'h020, 32'h0, 4'hF, 1'b1);
    cyc(1'b1, 1'b1, 10'h020, 32'hFF000000, 4'b1000, 1'b1);
    cyc(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);
    check("rst_exit_rvalid", {31'b0, rvalid}, 32'd0);
    cyc(1'b1, 1'b1, 10'h020, 32'h0, 4'h0, 1'b1);
    check("abort_020", rdata, 32'h00000000);
    cyc(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);

    // Random traffic over a small address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [SW-1:0] s;
      int k;
      k = $urandom_range(0, 2);
      s = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : 4'($urandom);
      cyc(($urandom_range(0, 60) != 0), 1'($urandom), AW'($urandom_range(0, 7)),
          32'($urandom), s, ($urandom_range(0, 3) != 0));
    end
    cyc(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_sp_ram_bstrb_ctrl.md
IOB_SP_RAM_BSTRB_CTRL -- requirements
Module: iob_sp_ram_bstrb_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10: word address width.
REQ-003 SHALL have one clock and a synchronous, active-low reset, ports named clk and reset_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 valid  input  1  front-end request valid.
REQ-007 addr  input  ADDR_W  request word address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 wstrb  input  DATA_W/8  byte strobes; all-zero means read.
REQ-010 ready  output  1  request accepted this cycle when valid&ready.
REQ-011 rvalid  output  1  read data valid.
REQ-012 rdata  output  DATA_W  read data.
REQ-013 rready  input  1  consumer accepts rdata.
REQ-014 ram_en, ram_we  output  1 each  RAM enable / write enable.
REQ-015 ram_addr  output  ADDR_W; ram_din  output  DATA_W; ram_dout  input  DATA_W (RAM registered read data, held while no RAM read).

Function
REQ-016 States SHALL be IDLE and RMW; rvalid SHALL be a separate flag.
REQ-017 ready SHALL be 1 iff state==IDLE and (rvalid==0 or rready==1).
REQ-018 Read accept (wstrb==0): same cycle ram_en=1, ram_we=0, ram_addr=addr; next cycle rvalid=1 (latency 1).
REQ-019 rdata SHALL equal ram_dout combinationally; controller SHALL issue no RAM read while rvalid&~rready, so rdata is stable under backpressure.
REQ-020 rvalid SHALL clear on rvalid&rready unless a new read is accepted that same cycle, in which case it stays 1.
REQ-021 Full write (wstrb all ones): same cycle ram_en=1, ram_we=1, ram_din=wdata; no response; state stays IDLE.
REQ-022 Partial write (wstrb neither zero nor all ones): accept cycle issues RAM read of addr and latches addr/wdata/wstrb; state->RMW.
REQ-023 In RMW: ram_en=1, ram_we=1, ram_addr=latched addr, ram_din byte i = wstrb[i] ? wdata byte i : ram_dout byte i; ready=0; state->IDLE next cycle.
REQ-024 Partial write SHALL occupy 2 cycles; back-to-back full writes/reads SHALL sustain 1 per cycle.
REQ-025 Writes SHALL never assert rvalid; a partial write SHALL not be accepted while an unconsumed read response is held (covered by REQ-017).
REQ-026 Read accepted the cycle after any write to the same address SHALL return the written value.
REQ-027 ram_en SHALL be 0 in any cycle with no accepted request and state==IDLE.

Reset
REQ-028 On reset_n==0 at clk edge: state=IDLE, rvalid=0, latched request cleared.
REQ-029 While reset_n==0: ready=0, ram_en=0, ram_we=0.
REQ-030 Reset during RMW SHALL abort the merge; the RAM write SHALL not occur.

Structure
REQ-031 State encodings and strobe-width constant SHALL live in the shared package iob_cache_pkg.
REQ-032 Byte merge SHALL be a combinational sub-module iob_byte_merge (DATA_W param).
REQ-033 RAM SHALL be external; controller instantiates no memory.

Verification
REQ-034 Full write addr 0x005=0xDEADBEEF, then read 0x005 -> rvalid one cycle later, rdata=0xDEADBEEF.
REQ-035 Word 0x010=0x11223344, partial write wstrb=4'b0101 wdata=0xAABBCCDD -> ready low one cycle; read gives 0x11BB33DD.
REQ-036 Read 0x005 with rready=0 for 5 cycles -> rvalid and rdata=0xDEADBEEF stable, ready=0, ram_en=0 throughout.
REQ-037 Stream reads 0x000..0x003 with rready=1 -> one response per cycle, in order, rvalid continuously 1.
REQ-038 reset_n=0 during RMW of 0x020 (old 0x00000000, wstrb=4'b1000, wdata=0xFF000000) -> after reset, read 0x020 = 0x00000000, rvalid=0 at reset exit.
REQ-039 Partial write 0x030 then immediate read 0x030 -> read accepted after RMW cycle, returns merged value.
